// File: rtl/seq_rotator.sv
// seq_rotator: multi-cycle 16-bit rotator, one bit per cycle; rev 1.0
// Optional macro SEQ_ROTATOR_SHIFT_EN enables logical-shift mode via b[5].
`default_nettype none

module seq_rotator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        inv,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_count;
  logic [15:0] r_result;
  logic        r_left;
  logic        w_accept;
  logic        w_fill_l;
  logic        w_fill_r;
  logic [15:0] w_step;
  logic        w_unused;

  assign w_accept = start && (r_state != S_RUN);
  assign w_unused = ^b[15:5];

`ifdef SEQ_ROTATOR_SHIFT_EN
  logic r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 1'b0;
    end else if (w_accept) begin
      r_shift <= b[5];
    end
  end

  assign w_fill_l = r_shift ? 1'b0 : r_result[15];
  assign w_fill_r = r_shift ? 1'b0 : r_result[0];
`else
  assign w_fill_l = r_result[15];
  assign w_fill_r = r_result[0];
`endif

  assign w_step = r_left ? {r_result[14:0], w_fill_l}
                         : {w_fill_r, r_result[15:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (b[4:1] != 4'd0) ? S_RUN : S_DONE;
      S_RUN:  if (r_count == 4'd1) w_next = S_DONE;
      S_DONE: begin
        if (w_accept) w_next = (b[4:1] != 4'd0) ? S_RUN : S_DONE;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= 4'd0;
      r_result <= 16'h0000;
      r_left   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_result <= a;
        r_count  <= b[4:1];
        r_left   <= b[0] ^ inv;
      end else if (r_state == S_RUN) begin
        r_result <= w_step;
        r_count  <= r_count - 4'd1;
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_rotator.sv
// tb_seq_rotator: randomized scoreboard bench for seq_rotator.
`default_nettype none

module tb_seq_rotator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        inv;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [15:0] res;
    int          at_cyc;
  } exp_t;

  exp_t q[$];

  seq_rotator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .inv    (inv),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic minv);
    int          n;
    bit          left;
    bit          sh;
    logic [31:0] w;
    n    = int'(mb[4:1]);
    left = mb[0] ^ minv;
    sh   = 1'b0;
`ifdef SEQ_ROTATOR_SHIFT_EN
    sh   = mb[5];
`endif
    if (sh) return left ? (ma << n) : (ma >> n);
    if (left) begin
      w = {ma, ma} << n;
      return w[31:16];
    end
    w = {ma, ma} >> n;
    return w[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Caller is positioned at a negedge; start is held until the next negedge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic iinv);
    int   k;
    exp_t e;
    k = 0;
    while (busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: busy=%b, required 0", busy);
    end
    start    = 1'b1;
    a        = ia;
    b        = ib;
    inv      = iinv;
    e.res    = model(ia, ib, iinv);
    e.at_cyc = cyc + 1 + int'(ib[4:1]);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        compared++;
        if (result !== e.res || cyc != e.at_cyc) begin
          mismatched++;
          $display("FAIL done_result: got %h at cycle %0d, required %h at cycle %0d",
                   result, cyc, e.res, e.at_cyc);
        end
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    inv   = 1'b0;
    #1;
    check("reset_result", result, 16'h0000);
    check("reset_busy", {15'h0, busy}, 16'h0);
    check("reset_done", {15'h0, done}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(16'h8001, 16'h0003, 1'b0);
    issue(16'h8001, 16'h0002, 1'b0);
    issue(16'h0001, 16'h001F, 1'b0);
    issue(16'h1234, 16'h0009, 1'b1);
    issue(16'h1234, 16'h0001, 1'b0);
    issue(16'h8001, 16'h0023, 1'b0);
    issue(16'hBEEF, 16'h0000, 1'b1);

    // A start pulse in the middle of a run must be ignored.
    issue(16'hA5C3, 16'h0014, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 16'h5A5A;
    b     = 16'h0002;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // Reset in mid-run drops the pending operation entirely.
    issue(16'hC0DE, 16'h0010, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_result", result, 16'h0000);
    check("midrun_reset_busy", {15'h0, busy}, 16'h0);
    check("midrun_reset_done", {15'h0, done}, 16'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0F0F, 16'h0007, 1'b0);
    issue(16'h8421, 16'h001E, 1'b1);

    k = 0;
    while (q.size() != 0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_rotator.md
SEQ_ROTATOR -- requirements
Module: seq_rotator

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on rising clk edge.
REQ-005 a  input  16  operand to rotate; captured when start accepted.
REQ-006 b  input  16  control word; b[0]=1 left, b[0]=0 right; b[4:1] bit count n (0..15); captured with a.
REQ-007 inv  input  1  reverse direction (undo mode); captured with a.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle completion pulse, high while state is DONE.
REQ-010 result  output  16  rotated value, held stable from done until next accepted start.

Function
REQ-011 States: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-012 Effective direction: left when b[0] XOR inv is 1, right otherwise.
REQ-013 start accepted only in IDLE or DONE; start during RUN is ignored with no effect on state, count or result.
REQ-014 On accept: result <= a, count <= n; next state RUN if n>=1, DONE if n==0.
REQ-015 Each RUN cycle: one 1-bit rotate of result (left: {r[14:0],r[15]}; right: {r[0],r[15:1]}), count decremented.
REQ-016 RUN -> DONE on the edge where count==1; DONE -> IDLE next edge unless a new start is accepted (DONE -> RUN/DONE).
REQ-017 Latency: done high exactly n+1 cycles after the accepting edge, for all n in 0..15.
REQ-018 Back-to-back: start held high in DONE accepts a new operation; done then drops for at least one cycle if new n>=1.
REQ-019 n==0: result equals a, no rotate step performed.
REQ-020 Upper bits b[15:5] ignored (except per REQ-025).
REQ-021 Result bit-exact to a combinational rotate of a by n in the effective direction.

Reset
REQ-022 rst_n low: state=IDLE, count=0, result=16'h0000, busy=0, done=0, immediately, independent of clk.
REQ-023 Reset during RUN abandons the operation; no done pulse is produced for it.
REQ-024 After rst_n release, first start accepted on first rising edge with rst_n high.

Configuration
REQ-025 Macro SEQ_ROTATOR_SHIFT_EN: when defined, captured b[5]=1 selects logical shift (vacated bit filled with 0) instead of rotate, same direction/count/latency rules; when undefined, b[5] ignored and only rotate exists.

Verification
REQ-026 a=16'h8001, b=16'h0003, inv=0 -> result 16'h0003, done 2 cycles after start.
REQ-027 a=16'h8001, b=16'h0002 -> result 16'hC000, done 2 cycles after start; a=16'h0001, b=16'h001F -> 16'h8000, done at cycle 16.
REQ-028 a=16'h1234, b=16'h0009, inv=1 (right 4) -> 16'h4123; b=16'h0001 (n=0) -> 16'h1234, done at cycle 1.
REQ-029 start re-pulsed during RUN with different a -> ignored, original result delivered; rst_n low at RUN cycle 3 -> result 0, busy 0, no done.
REQ-030 SEQ_ROTATOR_SHIFT_EN defined: a=16'h8001, b=16'h0023 -> 16'h0002; undefined: same stimulus -> 16'h0003.
